// File: rtl/lsu_pkg.sv
// Shared defaults and FSM encodings for the RISC16 memory-stage load/store unit.
package lsu_pkg;
  localparam int LSU_DW      = 16;
  localparam int LSU_AW      = 16;
  localparam int LSU_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_REQ  = 3'b010,
    ST_DONE = 3'b100
  } lsu_state_e;
endpackage

// File: rtl/lsu_wait_timer.sv
// 4-bit wait-state counter; expired flags the last REQ cycle allowed before timeout.
module lsu_wait_timer
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam logic [3:0] LAST = 4'(TIMEOUT - 1);

  logic [3:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  count <= '0;
    else if (clr)  count <= '0;
    else if (inc)  count <= count + 4'd1;
  end

  assign expired = (count == LAST);
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller: req/ack handshake to data memory, registered
// load data DS and writeback select, with a wait-state timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DW      = LSU_DW,
  parameter int AW      = LSU_AW,
  parameter int TIMEOUT = LSU_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ls_start,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_busy,
  output logic          ls_done,
  output logic          ls_err,
  output logic [DW-1:0] DS,
  output logic          ds_sel,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);
  lsu_state_e state;
  logic       we_q;
  logic       expired;

  lsu_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state == ST_IDLE),
    .inc     ((state == ST_REQ) && !mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_req   <= 1'b0;
      ls_done   <= 1'b0;
      ls_err    <= 1'b0;
      ds_sel    <= 1'b0;
      DS        <= '0;
    end else begin
      ls_done <= 1'b0;
      ls_err  <= 1'b0;
      ds_sel  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ls_start) begin
            we_q      <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_req   <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // ack takes priority over expiry so a last-cycle ack still succeeds
          if (mem_ack) begin
            mem_req <= 1'b0;
            ls_done <= 1'b1;
            ds_sel  <= ~we_q;
            if (!we_q) DS <= mem_rdata;
            state   <= ST_DONE;
          end else if (expired) begin
            mem_req <= 1'b0;
            ls_done <= 1'b1;
            ls_err  <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_we  = we_q & mem_req;
  assign ls_busy = (state == ST_REQ) || (state == ST_DONE);
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic, checked every
// cycle against a transaction-level reference model.
module tb_load_store_unit;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ls_start = 1'b0, ls_we = 1'b0;
  logic [15:0] ls_addr = '0, ls_wdata = '0;
  logic        ls_busy, ls_done, ls_err, ds_sel;
  logic [15:0] DS;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  load_store_unit dut (
    .clk(clk), .reset_n(reset_n), .ls_start(ls_start), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_busy(ls_busy), .ls_done(ls_done),
    .ls_err(ls_err), .DS(DS), .ds_sel(ds_sel), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: m_ph = 0 idle, k>0 means k-th cycle of the memory request, -1 = completion cycle.
  int          m_ph = 0;
  logic        m_err = 1'b0, m_sel = 1'b0, m_we = 1'b0;
  logic [15:0] m_ds = '0, m_addr = '0, m_wdata = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph <= 0; m_ds <= '0; m_err <= 1'b0; m_sel <= 1'b0;
    end else if (m_ph == 0) begin
      if (ls_start) begin
        m_ph <= 1; m_we <= ls_we; m_addr <= ls_addr; m_wdata <= ls_wdata;
      end
    end else if (m_ph > 0) begin
      if (mem_ack) begin
        m_ph <= -1; m_err <= 1'b0; m_sel <= !m_we;
        if (!m_we) m_ds <= mem_rdata;
      end else if (m_ph == TO) begin
        m_ph <= -1; m_err <= 1'b1; m_sel <= 1'b0;
      end else begin
        m_ph <= m_ph + 1;
      end
    end else begin
      m_ph <= 0;
    end
  end

  always @(negedge clk) begin
    chk("mem_req", mem_req, m_ph > 0);
    chk("ls_busy", ls_busy, m_ph != 0);
    chk("ls_done", ls_done, m_ph < 0);
    chk("ls_err",  ls_err,  (m_ph < 0) && m_err);
    chk("ds_sel",  ds_sel,  (m_ph < 0) && m_sel);
    chk("DS",      DS,      m_ds);
    if (m_ph > 0) begin
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_we",    mem_we,    m_we);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one access from IDLE; ack on the ack_at-th request cycle (0 = never).
  // Returns with the bench sitting in the completion cycle.
  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] rdata, input int ack_at,
                        output int nreq, output int lat);
    nreq = 0;
    ls_start = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
    step();
    lat = 1;
    ls_start = 1'b0;
    while (!ls_done && lat < 40) begin
      if (mem_req) begin
        nreq++;
        chk("held_addr", mem_addr, addr);
        chk("held_wdata", mem_wdata, wdata);
        if (nreq == ack_at) begin mem_ack = 1'b1; mem_rdata = rdata; end
      end
      step();
      mem_ack = 1'b0;
      lat++;
    end
    chk("done_seen", ls_done, 1'b1);
  endtask

  initial begin
    int nreq, lat, rc, nd, ackn;
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // zero-wait load
    access(1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1, nreq, lat);
    chk("zw_latency", lat, 2);
    chk("zw_sel", ds_sel, 1'b1);
    chk("zw_err", ls_err, 1'b0);
    chk("zw_ds", DS, 16'hBEEF);
    chk("model_ds", m_ds, 16'hBEEF);
    step();

    // store with three wait states
    access(1'b1, 16'h1234, 16'hA5A5, 16'h7777, 4, nreq, lat);
    chk("st_req_cycles", nreq, 4);
    chk("st_sel", ds_sel, 1'b0);
    chk("st_ds", DS, 16'hBEEF);
    step();

    // timeout
    access(1'b0, 16'hFFFF, 16'h0000, 16'h0000, 0, nreq, lat);
    chk("to_req_cycles", nreq, TO);
    chk("to_err", ls_err, 1'b1);
    chk("to_sel", ds_sel, 1'b0);
    chk("to_ds", DS, 16'hBEEF);
    step();

    // ack in final allowed cycle
    access(1'b0, 16'h0000, 16'h0000, 16'h0001, TO, nreq, lat);
    chk("bd_req_cycles", nreq, TO);
    chk("bd_err", ls_err, 1'b0);
    chk("bd_ds", DS, 16'h0001);
    step();

    // reset during second request cycle
    ls_start = 1'b1; ls_we = 1'b0; ls_addr = 16'h2222;
    step();
    ls_start = 1'b0;
    step();
    #1 reset_n = 1'b0;
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_ds", DS, 16'h0000);
    chk("rst_busy", ls_busy, 1'b0);
    step();
    chk("rst_done", ls_done, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    access(1'b0, 16'h3333, 16'h0000, 16'h1357, 2, nreq, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_ds", DS, 16'h1357);
    step();

    // ls_start held for 10 cycles, ack after one wait each time
    rc = 0; nd = 0;
    ls_we = 1'b0; ls_addr = 16'h0100;
    for (int c = 0; c < 20; c++) begin
      ls_start = (c < 10);
      mem_ack = 1'b0;
      if (mem_req) begin
        rc++;
        if (rc == 2) begin mem_ack = 1'b1; mem_rdata = 16'(c); rc = 0; end
      end
      step();
      if (ls_done) nd++;
    end
    chk("held_start_accesses", nd, 3);
    ls_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mem_ack = 1'b1;
      step();
      chk("idle_ack_busy", ls_busy, 1'b0);
    end
    mem_ack = 1'b0;
    step();

    // random traffic
    ackn = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom % 4)
          0: ackn = 1;
          1: ackn = 2;
          2: ackn = 4;
          default: ackn = 40;
        endcase
      end
      ls_start = ($urandom % 4) == 0;
      ls_we    = 1'($urandom % 2);
      if ($urandom % 8 == 0) ls_addr = ($urandom % 2) ? 16'hFFFF : 16'h0000;
      else ls_addr = 16'($urandom);
      ls_wdata  = 16'($urandom);
      mem_rdata = 16'($urandom);
      mem_ack   = ($urandom % ackn) == 0;
      step();
    end
    ls_start = 1'b0; mem_ack = 1'b0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage controller of the RISC16 datapath. Sits directly upstream of the writeback select mux.
- Takes one load/store request per instruction and runs a req/ack handshake with the data memory.
- Outputs the registered load data DS and the select bit ds_sel. Both feed the writeback mux, which picks DS (sel=1) or the ALU result S (sel=0).
- Includes a wait-state timeout so a dead memory cannot hang the core.

Parameters:
- DW, 16, data width (DS, ls_wdata, mem_rdata, mem_wdata).
- AW, 16, word-address width.
- TIMEOUT, 15, maximum number of REQ cycles before an error is declared (range 1..15; 4-bit counter).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- ls_start  in  1  request strobe; sampled only in IDLE.
- ls_we  in  1  1 = store, 0 = load; latched with ls_start.
- ls_addr  in  AW  word address; latched with ls_start.
- ls_wdata  in  DW  store data; latched with ls_start.
- ls_busy  out  1  high in REQ and DONE.
- ls_done  out  1  one-cycle completion pulse.
- ls_err  out  1  high with ls_done when the access timed out.
- DS  out  DW  registered load data to the writeback mux.
- ds_sel  out  1  writeback mux select; 1 = DS.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid when mem_ack=1.
- mem_ack  in  1  memory acknowledge; single-cycle.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs 0, including DS=0, mem_req=0 and the latched address, data and we registers.
  - Asserting reset mid-access drops mem_req immediately and discards the access. No ls_done is issued.
- FSM states: IDLE, REQ, DONE. Encoding is one-hot, 3 bits.
- IDLE:
  - ls_start=1 latches ls_we, ls_addr and ls_wdata, clears the wait counter and moves to REQ.
  - mem_ack in IDLE is ignored.
- REQ:
  - Drives mem_req=1 with mem_we, mem_addr and mem_wdata taken from the latches. These are stable for the whole REQ period.
  - mem_ack=1 moves to DONE. If the access is a load, mem_rdata is captured into DS on that edge.
  - mem_ack=0: the counter increments. If the counter equals TIMEOUT-1, move to DONE with the error flag set. mem_req is therefore held for exactly TIMEOUT cycles at most.
  - If mem_ack arrives in the final allowed cycle, ack wins: the access succeeds and no error is flagged.
- DONE (one cycle), then return to IDLE:
  - ls_done=1.
  - ls_err = error flag.
  - ds_sel=1 only for a successful load. It is 0 for stores and for errors.
- Outputs ls_done, ls_err and ds_sel are registered and are 0 outside DONE.
- DS holds its value until the next successful load. It is unchanged by stores and timeouts.
- ls_start is ignored in REQ and DONE; there is no queueing. The earliest back-to-back start is the IDLE cycle after DONE.
- Latency, with ls_start in cycle 0:
  - mem_req is high from cycle 1.
  - An ack in cycle k gives ls_done in cycle k+1.
  - Minimum (zero-wait) latency: ls_done in cycle 2.
- No alignment or address checks. Address 0 and 0xFFFF are both legal.

Decomposition:
- Package lsu_pkg holds:
  - state encodings ST_IDLE, ST_REQ, ST_DONE;
  - the TIMEOUT default;
  - the DW and AW defaults.
- One sub-module: lsu_wait_timer. It is a 4-bit counter with clear and increment inputs and an expired output (count == TIMEOUT-1).

Test Plan:
- Zero-wait load: ls_start, ls_we=0, ls_addr=0x0040; mem_ack in the first REQ cycle with mem_rdata=0xBEEF -> ls_done in cycle 2, ds_sel=1, DS=0xBEEF, ls_err=0.
- 3-wait store: ls_we=1, ls_addr=0x1234, ls_wdata=0xA5A5; ack on the 4th REQ cycle -> mem_req high for exactly 4 cycles with stable addr/data, ls_done with ds_sel=0, DS unchanged.
- Timeout: load with mem_ack never asserted -> mem_req high for exactly 15 cycles, then ls_done=1, ls_err=1, ds_sel=0, DS keeps 0xBEEF.
- Boundary: ack in the 15th REQ cycle with mem_rdata=0x0001 -> ls_err=0, DS=0x0001.
- Reset mid-access: reset_n pulled low during REQ cycle 2 -> mem_req=0 asynchronously, DS=0, no ls_done; a new load after reset completes normally.
- ls_start held high for 10 cycles with ack after 1 wait -> only one access per IDLE visit; a second access starts the cycle after DONE; mem_ack pulses in IDLE cause no state change.
